mult_feeder: RTL and testbench
==============================

# mult_feeder

Sequencer that drives the multiplier-switch array from the distribution side. On each job it accepts one stationary beat from an upstream buffer and forwards it with the stationary flag set. It then streams a programmed number of vector beats as plain valid beats. It produces the registered valid, stationary and data-bus triple the multiplier array consumes, applying a per-lane PE mask so that unused lanes carry zero.

## Interface
Parameters:
- IN_DATA_TYPE, 16, width of one PE operand
- NUM_PES, 64, number of multiplier lanes
- CNT_WIDTH, 16, width of the streamed-vector count

Ports:
- CLK  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- i_start  in  1  single-cycle job start; honoured only in IDLE
- i_num_vectors  in  CNT_WIDTH  streaming beats in this job; sampled with i_start
- i_pe_mask  in  NUM_PES  lane enables (bit k = lane k); sampled with i_start
- i_src_valid  in  1  upstream beat available
- i_src_data  in  NUM_PES*IN_DATA_TYPE  upstream beat, lane k at [k*IN_DATA_TYPE +: IN_DATA_TYPE]
- o_src_ready  out  1  feeder accepts a beat this cycle
- o_valid  out  1  beat presented to the multiplier array
- o_stationary  out  1  current o_valid beat is the stationary load
- o_data_bus  out  NUM_PES*IN_DATA_TYPE  masked operands to the array
- o_busy  out  1  job in progress (state is not IDLE)
- o_done  out  1  one-cycle pulse at job end

## Operation
- States: IDLE, LOAD, STREAM, DONE.
- IDLE:
  - On i_start: latch i_num_vectors into rem_cnt and i_pe_mask into mask_r, then go to LOAD.
- LOAD:
  - o_src_ready=1.
  - On accept (i_src_valid & o_src_ready), emit one beat with o_stationary=1.
  - Go to STREAM if rem_cnt≠0, otherwise to DONE.
- STREAM:
  - o_src_ready=1.
  - Each accept emits one beat with o_stationary=0 and decrements rem_cnt.
  - On the accept where rem_cnt==1, go to DONE.
- DONE:
  - o_done=1 for this single cycle, o_src_ready=0.
  - Go to IDLE next cycle.
- o_src_ready is 0 in IDLE and DONE. It is combinational from state only and never depends on i_src_valid.
- Emitted beats:
  - Masked lanes drive zero: lane k = i_src_data lane k if mask_r[k], else 0.
  - When o_valid=0, o_data_bus is 0 and o_stationary is 0.
- Source stall: in LOAD/STREAM with i_src_valid=0, nothing is emitted and no state or count change occurs.
- i_start in any state other than IDLE is ignored. i_start in the DONE cycle is also ignored.
- i_num_vectors=0: LOAD → DONE, so exactly one stationary beat is emitted.
- Counting: rem_cnt is CNT_WIDTH bits and never wraps, because the decrement occurs only when rem_cnt≥1.

## Timing
- Outputs o_valid, o_stationary and o_data_bus are registered. A beat accepted in cycle t appears in cycle t+1.
- o_busy and o_done are decoded from registered state.
- o_done rises in the cycle after the last beat is accepted, which is the same cycle that beat appears on o_valid.
- Throughput: one beat per cycle while i_src_valid is held high.
- A job of N vectors occupies 1 (IDLE→LOAD) + (N+1) accept cycles + 1 DONE cycle = N+3 cycles minimum.
- Reset values: state=IDLE, rem_cnt=0, mask_r=0, o_valid=0, o_stationary=0, o_data_bus=0, o_done=0, o_busy=0, o_src_ready=0.
- Reset asserted mid-job clears everything immediately, with no partial beat or done pulse. After release the block waits in IDLE for a new i_start.
- The multiplier array adds its own input register. End-to-end latency from accept to the multiply is accounted for downstream, not here.

## Structure
- A shared package holds the state enum (IDLE=2'd0, LOAD=2'd1, STREAM=2'd2, DONE=2'd3) and the default IN_DATA_TYPE/NUM_PES constants, which are shared with the multiplier array.
- One sub-module, feeder_lane_mask: a purely combinational generate loop that zeroes lanes per mask_r.
- The FSM, counter and output registers stay in the top.

## Test plan
- Basic job: start with num_vectors=3, mask all ones, src_valid held high, lane values 1..64 per beat. Required: 4 consecutive o_valid beats, the first with o_stationary=1, data equal to the input, o_done in the cycle of the 4th beat, o_busy high for 5 cycles.
- Zero vectors: num_vectors=0. Required: exactly one o_valid beat with o_stationary=1, o_done the same cycle, no o_stationary=0 beats.
- Stalls: num_vectors=4 with src_valid toggling 1,0,0,1,1,0,1,1. Required: 5 beats total, o_valid gaps aligned to stalls, rem_cnt not decremented on stalls, o_done after the 5th accept.
- Mask: mask=64'h0000_0000_FFFF_FFFF with all lanes 16'hABCD. Required: lanes 0–31 carry ABCD, lanes 32–63 carry 0, on every beat.
- Ignored start: i_start pulsed during STREAM and during DONE. Required: no count reload, no extra job; a new i_start in IDLE then runs normally.
- Reset mid-stream: rst low after the 2nd streamed beat of a 10-vector job. Required: all outputs 0 asynchronously, o_done never pulses, the block is idle after release.

Source files
------------

// File: rtl/mult_feeder_pkg.sv
// Shared definitions for the multiplier-array feeder: sequencer state encoding
// and the default operand/lane sizing shared with the multiplier array.
package mult_feeder_pkg;

    localparam int DEF_IN_DATA_TYPE = 16;
    localparam int DEF_NUM_PES      = 64;
    localparam int DEF_CNT_WIDTH    = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/feeder_lane_mask.sv
// Combinational lane gate: each PE lane passes its operand when its mask bit
// is set and drives zero otherwise.
module feeder_lane_mask
    import mult_feeder_pkg::*;
#(
    parameter int IN_DATA_TYPE = DEF_IN_DATA_TYPE,
    parameter int NUM_PES      = DEF_NUM_PES
) (
    input  logic [NUM_PES-1:0]              mask,
    input  logic [NUM_PES*IN_DATA_TYPE-1:0] data_in,
    output logic [NUM_PES*IN_DATA_TYPE-1:0] data_out
);

    for (genvar k = 0; k < NUM_PES; k++) begin : g_lane
        assign data_out[k*IN_DATA_TYPE +: IN_DATA_TYPE] =
            mask[k] ? data_in[k*IN_DATA_TYPE +: IN_DATA_TYPE] : '0;
    end

endmodule

// File: rtl/mult_feeder.sv
// Job sequencer feeding the multiplier-switch array: one stationary beat, then
// a programmed number of streamed vector beats, with registered masked outputs.
module mult_feeder
    import mult_feeder_pkg::*;
#(
    parameter int IN_DATA_TYPE = DEF_IN_DATA_TYPE,
    parameter int NUM_PES      = DEF_NUM_PES,
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
    input  logic                              CLK,
    input  logic                              rst,
    input  logic                              i_start,
    input  logic [CNT_WIDTH-1:0]              i_num_vectors,
    input  logic [NUM_PES-1:0]                i_pe_mask,
    input  logic                              i_src_valid,
    input  logic [NUM_PES*IN_DATA_TYPE-1:0]   i_src_data,
    output logic                              o_src_ready,
    output logic                              o_valid,
    output logic                              o_stationary,
    output logic [NUM_PES*IN_DATA_TYPE-1:0]   o_data_bus,
    output logic                              o_busy,
    output logic                              o_done
);

    localparam int BUS_W = NUM_PES * IN_DATA_TYPE;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    feeder_state_t        state_q;
    feeder_state_t        state_d;
    logic [CNT_WIDTH-1:0] rem_cnt;
    logic [NUM_PES-1:0]   mask_r;
    logic                 accept;
    logic [BUS_W-1:0]     masked_data;

    assign accept = i_src_valid & o_src_ready;

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    state_d = (rem_cnt != '0) ? STREAM : DONE;
                end
            end
            STREAM: begin
                if (accept && rem_cnt == CNT_ONE) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Ready depends on state alone so the upstream buffer never sees a
    // combinational path back from its own valid.
    always_comb begin
        o_src_ready = (state_q == LOAD) || (state_q == STREAM);
        o_busy      = (state_q != IDLE);
        o_done      = (state_q == DONE);
    end

    // The zero guard keeps the count from wrapping if STREAM is ever
    // entered with nothing left to send.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            rem_cnt <= '0;
            mask_r  <= '0;
        end else if (state_q == IDLE && i_start) begin
            rem_cnt <= i_num_vectors;
            mask_r  <= i_pe_mask;
        end else if (state_q == STREAM && accept && rem_cnt != '0) begin
            rem_cnt <= rem_cnt - CNT_ONE;
        end
    end

    feeder_lane_mask #(
        .IN_DATA_TYPE (IN_DATA_TYPE),
        .NUM_PES      (NUM_PES)
    ) u_lane_mask (
        .mask     (mask_r),
        .data_in  (i_src_data),
        .data_out (masked_data)
    );

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            o_valid      <= 1'b0;
            o_stationary <= 1'b0;
            o_data_bus   <= '0;
        end else begin
            o_valid      <= accept;
            o_stationary <= accept && (state_q == LOAD);
            o_data_bus   <= accept ? masked_data : '0;
        end
    end

endmodule

// File: tb/tb_mult_feeder.sv
// Self-checking bench for mult_feeder: table-driven jobs, hand-built corner
// sequences and randomized jobs against a job-level reference model.
module tb_mult_feeder;

    localparam int W  = 16;
    localparam int P  = 64;
    localparam int CW = 16;
    localparam int BW = P * W;

    logic          CLK = 1'b0;
    logic          rst;
    logic          i_start;
    logic [CW-1:0] i_num_vectors;
    logic [P-1:0]  i_pe_mask;
    logic          i_src_valid;
    logic [BW-1:0] i_src_data;
    logic          o_src_ready;
    logic          o_valid;
    logic          o_stationary;
    logic [BW-1:0] o_data_bus;
    logic          o_busy;
    logic          o_done;

    always #5 CLK = ~CLK;

    mult_feeder #(
        .IN_DATA_TYPE (W),
        .NUM_PES      (P),
        .CNT_WIDTH    (CW)
    ) dut (
        .CLK           (CLK),
        .rst           (rst),
        .i_start       (i_start),
        .i_num_vectors (i_num_vectors),
        .i_pe_mask     (i_pe_mask),
        .i_src_valid   (i_src_valid),
        .i_src_data    (i_src_data),
        .o_src_ready   (o_src_ready),
        .o_valid       (o_valid),
        .o_stationary  (o_stationary),
        .o_data_bus    (o_data_bus),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    int nCompared;
    int nMismatched;

    // Reference model: beats still owed to the current job (stationary one
    // included), plus the beat/done expected on the outputs this cycle.
    int            toAccept;
    logic          firstBeat;
    logic [P-1:0]  modelMask;
    logic          expValid;
    logic          expStat;
    logic          expDone;
    logic [BW-1:0] expData;

    int   obsBeats;
    int   obsStat;
    int   obsBusy;
    logic sawDone;

    typedef struct {
        int          num;
        logic [P-1:0] mask;
        logic [15:0] pattern;
        int          patLen;
        int          dataMode;
        int          expBeats;
        int          expStat;
        int          expBusy;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [BW-1:0] maskBeat(input logic [BW-1:0] d, input logic [P-1:0] m);
        logic [BW-1:0] r;
        r = '0;
        for (int k = 0; k < P; k++) begin
            if (m[k]) r[k*W +: W] = d[k*W +: W];
        end
        return r;
    endfunction

    function automatic logic [BW-1:0] makeData(input int mode);
        logic [BW-1:0] r;
        r = '0;
        for (int k = 0; k < P; k++) begin
            if (mode == 0)      r[k*W +: W] = W'(k + 1);
            else if (mode == 1) r[k*W +: W] = 16'hABCD;
            else                r[k*W +: W] = W'($urandom);
        end
        return r;
    endfunction

    task automatic compareBit(input string name, input logic act, input logic exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compareInt(input string name, input int act, input int exp);
        nCompared++;
        if (act != exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic compareBus(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        int bad;
        bad = -1;
        nCompared++;
        for (int k = 0; k < P; k++) begin
            if (bad < 0 && act[k*W +: W] !== exp[k*W +: W]) bad = k;
        end
        if (bad >= 0) begin
            nMismatched++;
            $display("[TB] FAIL %s lane %0d: got %h want %h at %0t",
                     name, bad, act[bad*W +: W], exp[bad*W +: W], $time);
        end
    endtask

    task automatic checkOutput();
        compareBit("o_valid", o_valid, expValid);
        compareBit("o_stationary", o_stationary, expStat);
        compareBus("o_data_bus", o_data_bus, expData);
        compareBit("o_src_ready", o_src_ready, toAccept > 0);
        compareBit("o_busy", o_busy, (toAccept > 0) || expDone);
        compareBit("o_done", o_done, expDone);
        if (o_valid === 1'b1) obsBeats++;
        if (o_valid === 1'b1 && o_stationary === 1'b1) obsStat++;
        if (o_busy === 1'b1) obsBusy++;
        if (o_done === 1'b1) sawDone = 1'b1;
    endtask

    // Drive one cycle of inputs, advance the model by that cycle, then wait
    // for the falling edge where the results are observed.
    task automatic applyStimulus(input logic start, input int num, input logic [P-1:0] mask,
                                 input logic valid, input logic [BW-1:0] data);
        logic acc;
        logic nextDone;
        i_start       = start;
        i_num_vectors = num[CW-1:0];
        i_pe_mask     = mask;
        i_src_valid   = valid;
        i_src_data    = data;
        acc      = (toAccept > 0) && valid;
        nextDone = acc && (toAccept == 1);
        expValid = acc;
        expStat  = acc && firstBeat;
        expData  = acc ? maskBeat(data, modelMask) : '0;
        if (acc) begin
            toAccept--;
            firstBeat = 1'b0;
        end else if (toAccept == 0 && !expDone && start) begin
            toAccept  = num + 1;
            firstBeat = 1'b1;
            modelMask = mask;
        end
        expDone = nextDone;
        @(negedge CLK);
    endtask

    task automatic clearObs();
        obsBeats = 0;
        obsStat  = 0;
        obsBusy  = 0;
        sawDone  = 1'b0;
    endtask

    task automatic modelReset();
        toAccept  = 0;
        firstBeat = 1'b0;
        modelMask = '0;
        expValid  = 1'b0;
        expStat   = 1'b0;
        expDone   = 1'b0;
        expData   = '0;
    endtask

    // One job from start to the DONE cycle; non-start cycles carry junk on
    // i_num_vectors/i_pe_mask which must not be latched.
    task automatic runJob(input int num, input logic [P-1:0] mask, input logic [15:0] pattern,
                          input int patLen, input int dataMode, input bit randomMode);
        int   idx;
        logic v;
        clearObs();
        checkOutput();
        applyStimulus(1'b1, num, mask, 1'b0, makeData(dataMode));
        idx = 0;
        while (idx < 400) begin
            checkOutput();
            if (sawDone) break;
            v = randomMode ? ($urandom_range(0, 9) < 7) : pattern[idx % patLen];
            applyStimulus(randomMode && ($urandom_range(0, 7) == 0), $urandom, ~mask, v,
                          makeData(dataMode));
            idx++;
        end
        compareBit("job reaches done", sawDone, 1'b1);
        applyStimulus(randomMode && ($urandom_range(0, 1) == 0), $urandom, ~mask, 1'b1,
                      makeData(dataMode));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        nCompared     = 0;
        nMismatched   = 0;
        rst           = 1'b0;
        i_start       = 1'b0;
        i_num_vectors = '0;
        i_pe_mask     = '0;
        i_src_valid   = 1'b0;
        i_src_data    = '0;
        modelReset();
        clearObs();

        vecs[0] = '{num: 3, mask: {P{1'b1}}, pattern: 16'hFFFF, patLen: 1, dataMode: 0,
                    expBeats: 4, expStat: 1, expBusy: 5};
        vecs[1] = '{num: 0, mask: {P{1'b1}}, pattern: 16'hFFFF, patLen: 1, dataMode: 2,
                    expBeats: 1, expStat: 1, expBusy: 2};
        vecs[2] = '{num: 4, mask: {P{1'b1}}, pattern: 16'h00D9, patLen: 8, dataMode: 2,
                    expBeats: 5, expStat: 1, expBusy: 9};
        vecs[3] = '{num: 2, mask: 64'h0000_0000_FFFF_FFFF, pattern: 16'hFFFF, patLen: 1,
                    dataMode: 1, expBeats: 3, expStat: 1, expBusy: 4};
        vecs[4] = '{num: 1, mask: {P{1'b1}}, pattern: 16'h0006, patLen: 3, dataMode: 2,
                    expBeats: 2, expStat: 1, expBusy: 4};

        repeat (2) @(negedge CLK);
        checkOutput();
        rst = 1'b1;
        $display("[TB] reset released, running table vectors");

        for (int i = 0; i < 5; i++) begin
            runJob(vecs[i].num, vecs[i].mask, vecs[i].pattern, vecs[i].patLen,
                   vecs[i].dataMode, 1'b0);
            compareInt($sformatf("vec%0d beats", i), obsBeats, vecs[i].expBeats);
            compareInt($sformatf("vec%0d stationary beats", i), obsStat, vecs[i].expStat);
            compareInt($sformatf("vec%0d busy cycles", i), obsBusy, vecs[i].expBusy);
        end

        // Starts during STREAM and during DONE must be ignored.
        $display("[TB] ignored-start sequence");
        clearObs();
        checkOutput();
        applyStimulus(1'b1, 5, {P{1'b1}}, 1'b0, makeData(2));
        for (int idx = 0; idx < 40; idx++) begin
            checkOutput();
            if (sawDone) break;
            applyStimulus(idx == 2, 100, '0, 1'b1, makeData(2));
        end
        compareBit("ignored-start job done", sawDone, 1'b1);
        applyStimulus(1'b1, 100, '0, 1'b1, makeData(2));
        compareInt("ignored-start beats", obsBeats, 6);
        compareInt("ignored-start stationary", obsStat, 1);
        clearObs();
        repeat (3) begin
            checkOutput();
            applyStimulus(1'b0, 7, '1, 1'b1, makeData(2));
        end
        compareInt("idle after ignored start", obsBusy, 0);
        runJob(2, {P{1'b1}}, 16'hFFFF, 1, 2, 1'b0);
        compareInt("job after ignored start beats", obsBeats, 3);

        // Asynchronous reset after the second streamed beat of a long job.
        $display("[TB] reset mid-stream sequence");
        clearObs();
        checkOutput();
        applyStimulus(1'b1, 10, {P{1'b1}}, 1'b0, makeData(2));
        for (int idx = 0; idx < 20; idx++) begin
            checkOutput();
            if (obsBeats >= 3) break;
            applyStimulus(1'b0, 0, '0, 1'b1, makeData(2));
        end
        compareInt("beats before reset", obsBeats, 3);
        #2 rst = 1'b0;
        #1;
        compareBit("reset o_valid", o_valid, 1'b0);
        compareBit("reset o_stationary", o_stationary, 1'b0);
        compareBus("reset o_data_bus", o_data_bus, '0);
        compareBit("reset o_busy", o_busy, 1'b0);
        compareBit("reset o_done", o_done, 1'b0);
        compareBit("reset o_src_ready", o_src_ready, 1'b0);
        modelReset();
        repeat (3) begin
            @(negedge CLK);
            compareBit("o_done held in reset", o_done, 1'b0);
            compareBit("o_valid held in reset", o_valid, 1'b0);
        end
        rst = 1'b1;
        clearObs();
        repeat (4) begin
            checkOutput();
            applyStimulus(1'b0, 3, '1, 1'b1, makeData(2));
        end
        compareInt("idle after reset busy", obsBusy, 0);
        compareInt("idle after reset done", int'(sawDone), 0);
        runJob(1, {P{1'b1}}, 16'hFFFF, 1, 2, 1'b0);
        compareInt("job after reset beats", obsBeats, 2);

        $display("[TB] randomized jobs");
        for (int j = 0; j < 40; j++) begin
            int           num;
            logic [P-1:0] mask;
            repeat ($urandom_range(0, 3)) begin
                checkOutput();
                applyStimulus(1'b0, $urandom, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                              makeData(2));
            end
            num  = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 30) : $urandom_range(0, 6);
            mask = {$urandom, $urandom};
            runJob(num, mask, 16'h0000, 1, 2, 1'b1);
            compareInt($sformatf("random job %0d beats", j), obsBeats, num + 1);
            compareInt($sformatf("random job %0d stationary", j), obsStat, 1);
        end
        checkOutput();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
